// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchronizer, mid-bit sampling FSM,
// framing checks and a first-word-fall-through receive FIFO.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clear,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_H = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          sync1, line;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, push;
  logic          stop_edge, stop_ok, ovr_set, frm_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= pin;
      line  <= sync1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = !empty;
  assign rx_data  = mem[rd_ptr[AW-1:0]];
  assign busy     = (state != IDLE);

  assign pop       = rx_valid && rx_ready;
  assign stop_edge = (state == STOP) && (cnt == CNT_C);
  assign stop_ok   = stop_edge && line;
  assign push      = stop_ok && (!full || pop);
  assign ovr_set   = stop_ok && full && !pop;
  assign frm_set   = stop_edge && !line;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!line) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_H) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= line ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_C) begin
            shreg   <= {line, shreg[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_C) begin
            cnt   <= '0;
            state <= line ? IDLE : BRK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // hold off until the line is released
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // a set in the same cycle as a clear keeps the flag
      frame_err <= frm_set || (frame_err && !err_clear);
      overrun   <= ovr_set || (overrun && !err_clear);
    end
  end

endmodule
